mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multicycle MIPS controller: Moore FSM that sequences fetch/decode/execute/memory/writeback
//  for lw, sw, R-type (add/sub/slt/mul), addi, beq and j over a shared memory and ALU.
//  Adds a memory ready handshake and illegal-instruction reporting.
//  Sits between the instruction register (Op_Code/Funct), the ALU zero flag and the multicycle datapath muxes/enables.
// PARAMETERS
//  Op_Code_Width      6  opcode field width
//  Funct_Width        6  funct field width
//  ALU_Control_Width  3  ALU operation select width
//  State_Width        4  state register width (13 states)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  Op_Code      in   6   opcode from instruction register
//  Funct        in   6   funct from instruction register
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   memory access completes this cycle
//  IorD         out  1   memory address: 0 = PC, 1 = ALUOut
//  Mem_write    out  1   memory write strobe
//  IR_write     out  1   instruction register load
//  Reg_Dest     out  1   write reg: 0 = rt, 1 = rd
//  Mem_to_Reg   out  1   write data: 0 = ALUOut, 1 = Data
//  Reg_write    out  1   register file write enable
//  Alu_Src_A    out  1   ALU A: 0 = PC, 1 = reg A
//  Alu_Src_B    out  2   ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//  PC_src       out  2   next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
//  PC_en        out  1   PC load = PC_write | (Branch & zero), combined inside the block
//  ALU_Control  out  3   010 add, 100 sub, 110 slt, 101 mul
//  instr_done   out  1   1-cycle pulse in final state of each instruction
//  illegal_op   out  1   1-cycle pulse in DECODE for an unsupported opcode or funct
// BEHAVIOUR
//  - Reset: async to IDLE. In IDLE every output is 0. IDLE -> FETCH unconditionally.
//  - FETCH: IorD=0, Alu_Src_A=0, Alu_Src_B=01, ALU=add, PC_src=00.
//    IR_write=PC_en=mem_ready. Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
//  - DECODE: Alu_Src_A=0, Alu_Src_B=11, ALU=add (branch target to ALUOut). Next state:
//    lw/sw -> MEMADR; R -> EXECUTE; addi -> ADDIEX; beq -> BRANCH; j -> JUMP; else -> FETCH with illegal_op=1.
//  - R-type with an unsupported funct is illegal: FETCH with illegal_op=1 and no register write.
//  - MEMADR: Alu_Src_A=1, Alu_Src_B=10, ALU=add. Next is MEMRD for lw, MEMWR for sw.
//  - MEMRD: IorD=1. Holds until mem_ready, then MEMWB.
//  - MEMWB: Reg_write=1, Mem_to_Reg=1, Reg_Dest=0, instr_done=1. Next is FETCH.
//  - MEMWR: IorD=1, Mem_write=1 every cycle while waiting. instr_done=mem_ready. Goes to FETCH on mem_ready.
//  - EXECUTE: Alu_Src_A=1, Alu_Src_B=00, ALU_Control from funct. Next is ALUWB.
//  - ALUWB: Reg_write=1, Reg_Dest=1, Mem_to_Reg=0, instr_done=1. Next is FETCH.
//  - ADDIEX: Alu_Src_A=1, Alu_Src_B=10, ALU=add. Next is ADDIWB.
//  - ADDIWB: Reg_write=1, Reg_Dest=0, Mem_to_Reg=0, instr_done=1. Next is FETCH.
//  - BRANCH: Alu_Src_A=1, Alu_Src_B=00, ALU=sub, PC_src=01, PC_en=zero, instr_done=1. Next is FETCH.
//  - JUMP: PC_src=10, PC_en=1, instr_done=1. Next is FETCH.
//  - Outputs not listed for a state are 0, except ALU_Control, which defaults to 010.
//  - Latency with mem_ready held at 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles (FETCH through last state).
//    Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
//  - mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
//  - rst asserted mid-instruction (any state): IDLE immediately. No partial write completes after reset asserts.
//  - Undefined state encodings recover to IDLE on the next clock.
// CONFIGURATION
//  BNE_EN defined: opcode 000101 (bne) goes DECODE -> BRANCH; in BRANCH PC_en=~zero for bne, all other outputs as beq.
//  BNE_EN undefined: 000101 is illegal (illegal_op pulse, return to FETCH).
// STRUCTURE
//  Shared package file mips_defines.vh holds:
//    opcode constants (lw 100011, sw 101011, R 000000, addi 001000, beq 000100, j 000010, bne 000101);
//    funct constants (add 100000, sub 100010, slt 101010, mul 011100);
//    ALU_Control codes; state encodings; ALU-op codes (00 add, 01 sub, 10 funct).
//  Sub-module mips_alu_decoder (combinational: Alu_op, Funct -> ALU_Control, funct_valid).
//  The FSM holds the state register, next-state logic and output decode.
// TESTING
//  - Reset mid-operation: rst=1 while in MEMRD -> same-cycle IDLE, all outputs 0; after release FETCH on the 2nd edge.
//  - lw, mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; 5 cycles; MEMWB shows Reg_write=1, Mem_to_Reg=1, instr_done=1.
//  - Memory stall: mem_ready=0 for 3 cycles in FETCH -> IR_write=PC_en=0 for those 3 cycles, then 1 for one cycle, then DECODE.
//  - R-type slt (Funct=101010): EXECUTE ALU_Control=110; ALUWB Reg_write=1, Reg_Dest=1. Funct=000111 -> illegal_op=1, no Reg_write.
//  - beq with zero=1 -> BRANCH PC_en=1, PC_src=01; with zero=0 -> PC_en=0; instr_done=1 both times.
//  - Opcode 111111 -> illegal_op pulse in DECODE, then FETCH, no Mem_write/Reg_write.
//    Opcode 000101 -> bne branch (BNE_EN defined) or illegal_op (BNE_EN undefined).

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the opcode and funct field values, the ALU_Control codes, the ALU-op
// codes handed to the ALU decoder, the FSM state encoding, and the per-state
// control word together with the functions that decode a state into it.
package mips_multicycle_control_pkg;

  localparam int unsigned State_Width = 4;

  // Opcode field values
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBne   = 6'b000101;

  // Funct field values for the supported R-type operations
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctSlt = 6'b101010;
  localparam logic [5:0] FunctMul = 6'b011100;

  // ALU_Control codes
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b100;
  localparam logic [2:0] AluSlt = 3'b110;
  localparam logic [2:0] AluMul = 3'b101;
  localparam logic [2:0] AluOff = 3'b000;

  // ALU-op handed to the decoder; AluOpNone drives ALU_Control to 000 (IDLE).
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpNone  = 2'b11
  } alu_op_e;

  typedef enum logic [State_Width-1:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExecute = 4'd7,
    StAluWb   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12
  } state_e;

  // Registered control word. gate_ready marks states whose IR_write, PC write
  // and instr_done only take effect in the cycle mem_ready is high.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       done;
    logic       gate_ready;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e st, input logic is_bne);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.alu_src_b  = 2'b01;
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.gate_ready = 1'b1;
      end
      StDecode: c.alu_src_b = 2'b11;
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRd: c.iord = 1'b1;
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      StMemWr: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.done       = 1'b1;
        c.gate_ready = 1'b1;
      end
      StExecute: c.alu_src_a = 1'b1;
      StAluWb: begin
        c.reg_write = 1'b1;
        c.reg_dest  = 1'b1;
        c.done      = 1'b1;
      end
      StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StAddiWb: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
        c.branch_ne = is_bne;
        c.done      = 1'b1;
      end
      StJump: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic alu_op_e state_alu_op(input state_e st);
    case (st)
      StIdle:    return AluOpNone;
      StExecute: return AluOpFunct;
      StBranch:  return AluOpSub;
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
      StAluWb, StAddiEx, StAddiWb, StJump: return AluOpAdd;
      default:   return AluOpNone;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder for the multicycle MIPS controller (combinational).
// Ports:
//   Alu_op      in   ALU-op from the FSM (add, sub, by-funct, none)
//   Funct       in   funct field of the instruction register
//   ALU_Control out  ALU operation select
//   funct_valid out  Funct is one of add/sub/slt/mul (independent of Alu_op)
module mips_multicycle_control_alu_decoder
  import mips_multicycle_control_pkg::*;
#(
  parameter int unsigned Funct_Width       = 6,
  parameter int unsigned ALU_Control_Width = 3
) (
  input  alu_op_e                      Alu_op,
  input  logic [Funct_Width-1:0]       Funct,
  output logic [ALU_Control_Width-1:0] ALU_Control,
  output logic                         funct_valid
);

  logic [ALU_Control_Width-1:0] funct_ctrl;

  // Kept separate from the Alu_op mux so funct_valid depends on Funct alone.
  always_comb begin
    funct_valid = 1'b1;
    funct_ctrl  = AluAdd;
    case (Funct)
      FunctAdd: funct_ctrl = AluAdd;
      FunctSub: funct_ctrl = AluSub;
      FunctSlt: funct_ctrl = AluSlt;
      FunctMul: funct_ctrl = AluMul;
      default: begin
        funct_valid = 1'b0;
        funct_ctrl  = AluAdd;
      end
    endcase
  end

  always_comb begin
    ALU_Control = AluOff;
    case (Alu_op)
      AluOpAdd:   ALU_Control = AluAdd;
      AluOpSub:   ALU_Control = AluSub;
      AluOpFunct: ALU_Control = funct_ctrl;
      default:    ALU_Control = AluOff;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute/memory/
// writeback for lw, sw, R-type (add/sub/slt/mul), addi, beq and j over a shared
// memory and ALU, with a memory-ready handshake and illegal-instruction pulse.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   Op_Code, Funct       instruction register fields
//   zero                 ALU zero flag
//   mem_ready            memory access completes this cycle
//   IorD .. ALU_Control  datapath mux selects and enables
//   PC_en                PC load, PC_write | (Branch & zero) folded in here
//   instr_done           pulse in the final state of each instruction
//   illegal_op           pulse in DECODE for an unsupported opcode or funct
// Build option: define BNE_EN to accept bne (000101) as a branch on ~zero;
// without it bne is reported as illegal.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int unsigned Op_Code_Width     = 6,
  parameter int unsigned Funct_Width       = 6,
  parameter int unsigned ALU_Control_Width = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Op_Code_Width-1:0]     Op_Code,
  input  logic [Funct_Width-1:0]       Funct,
  input  logic                         zero,
  input  logic                         mem_ready,
  output logic                         IorD,
  output logic                         Mem_write,
  output logic                         IR_write,
  output logic                         Reg_Dest,
  output logic                         Mem_to_Reg,
  output logic                         Reg_write,
  output logic                         Alu_Src_A,
  output logic [1:0]                   Alu_Src_B,
  output logic [1:0]                   PC_src,
  output logic                         PC_en,
  output logic [ALU_Control_Width-1:0] ALU_Control,
  output logic                         instr_done,
  output logic                         illegal_op
);

  state_e                       state_q, state_d;
  ctrl_t                        ctrl_q, ctrl_d;
  alu_op_e                      alu_op_d;
  logic [ALU_Control_Width-1:0] alu_control_q, alu_control_d;
  logic                         funct_valid;
  logic                         opcode_legal;
  logic                         is_bne;
  logic                         ready_ok;

  always_comb begin
    is_bne = 1'b0;
`ifdef BNE_EN
    is_bne = (Op_Code == OpBne);
`endif
  end

  always_comb begin
    opcode_legal = 1'b0;
    case (Op_Code)
      OpLw, OpSw, OpAddi, OpBeq, OpJ: opcode_legal = 1'b1;
      OpRtype:                        opcode_legal = funct_valid;
      default:                        opcode_legal = is_bne;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (!opcode_legal) begin
          state_d = StFetch;
        end else begin
          case (Op_Code)
            OpLw, OpSw: state_d = StMemAdr;
            OpRtype:    state_d = StExecute;
            OpAddi:     state_d = StAddiEx;
            OpBeq:      state_d = StBranch;
            OpJ:        state_d = StJump;
            default:    state_d = is_bne ? StBranch : StFetch;
          endcase
        end
      end
      StMemAdr:  state_d = (Op_Code == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
      StExecute: state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      default:   state_d = StIdle;
    endcase
  end

  // Control word and ALU select are decoded from the next state so they leave
  // the register already matching the state being entered.
  assign ctrl_d   = state_ctrl(state_d, is_bne);
  assign alu_op_d = state_alu_op(state_d);

  mips_multicycle_control_alu_decoder #(
    .Funct_Width       (Funct_Width),
    .ALU_Control_Width (ALU_Control_Width)
  ) u_alu_decoder (
    .Alu_op      (alu_op_d),
    .Funct       (Funct),
    .ALU_Control (alu_control_d),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ctrl_q        <= '0;
      alu_control_q <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      alu_control_q <= alu_control_d;
    end
  end

  // Handshake- and flag-qualified strobes must react within the current cycle.
  assign ready_ok    = ~ctrl_q.gate_ready | mem_ready;

  assign IorD        = ctrl_q.iord;
  assign Mem_write   = ctrl_q.mem_write;
  assign IR_write    = ctrl_q.ir_write & ready_ok;
  assign Reg_Dest    = ctrl_q.reg_dest;
  assign Mem_to_Reg  = ctrl_q.mem_to_reg;
  assign Reg_write   = ctrl_q.reg_write;
  assign Alu_Src_A   = ctrl_q.alu_src_a;
  assign Alu_Src_B   = ctrl_q.alu_src_b;
  assign PC_src      = ctrl_q.pc_src;
  assign PC_en       = (ctrl_q.pc_write & ready_ok) |
                       (ctrl_q.branch & (zero ^ ctrl_q.branch_ne));
  assign ALU_Control = alu_control_q;
  assign instr_done  = ctrl_q.done & ready_ok;
  assign illegal_op  = (state_q == StDecode) & ~opcode_legal;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control. Outputs are packed
// into one vector {IorD, Mem_write, IR_write, Reg_Dest, Mem_to_Reg, Reg_write,
// Alu_Src_A, Alu_Src_B, PC_src, PC_en, ALU_Control, instr_done, illegal_op}
// and compared against hand-written per-state expectations.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op_Code;
  logic [5:0] Funct;
  logic       zero;
  logic       mem_ready;
  logic       IorD, Mem_write, IR_write, Reg_Dest, Mem_to_Reg, Reg_write, Alu_Src_A;
  logic [1:0] Alu_Src_B, PC_src;
  logic       PC_en;
  logic [2:0] ALU_Control;
  logic       instr_done, illegal_op;
  logic [16:0] obs;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mips_multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .Op_Code     (Op_Code),
    .Funct       (Funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .IorD        (IorD),
    .Mem_write   (Mem_write),
    .IR_write    (IR_write),
    .Reg_Dest    (Reg_Dest),
    .Mem_to_Reg  (Mem_to_Reg),
    .Reg_write   (Reg_write),
    .Alu_Src_A   (Alu_Src_A),
    .Alu_Src_B   (Alu_Src_B),
    .PC_src      (PC_src),
    .PC_en       (PC_en),
    .ALU_Control (ALU_Control),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, Mem_write, IR_write, Reg_Dest, Mem_to_Reg, Reg_write, Alu_Src_A,
                Alu_Src_B, PC_src, PC_en, ALU_Control, instr_done, illegal_op};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ov(input logic iord, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, ps, input logic pcen,
                                     input logic [2:0] alu, input logic done, ill);
    return {iord, mw, irw, rd, m2r, rw, sa, sb, ps, pcen, alu, done, ill};
  endfunction

  // Advance one clock and settle away from the edge.
  task automatic step;
    @(posedge clk);
    #2;
  endtask

  logic [16:0] e_idle, e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_memadr, e_memrd;
  logic [16:0] e_memwb, e_memwr_wait, e_memwr, e_exec_slt, e_aluwb, e_addiex, e_addiwb;
  logic [16:0] e_br_taken, e_br_not, e_jump;

  initial begin
    //                   iord mw irw rd m2r rw sa  sb     ps     pcen alu     dn ill
    e_idle       = '0;
    e_fetch      = ov(0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 3'b010, 0, 0);
    e_fetch_wait = ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 3'b010, 0, 0);
    e_decode     = ov(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0);
    e_decode_ill = ov(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 1);
    e_memadr     = ov(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0);
    e_memrd      = ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0);
    e_memwb      = ov(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0);
    e_memwr_wait = ov(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0);
    e_memwr      = ov(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0);
    e_exec_slt   = ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b110, 0, 0);
    e_aluwb      = ov(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0);
    e_addiex     = ov(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0);
    e_addiwb     = ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0);
    e_br_taken   = ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 3'b100, 1, 0);
    e_br_not     = ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 3'b100, 1, 0);
    e_jump       = ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b010, 1, 0);

    rst = 1'b1; Op_Code = 6'b100011; Funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    #1 check_eq("reset_idle", obs, e_idle);
    @(negedge clk) rst = 1'b0;

    // lw, memory always ready: 5 cycles FETCH..MEMWB
    step; check_eq("lw_fetch", obs, e_fetch);
    step; check_eq("lw_decode", obs, e_decode);
    step; check_eq("lw_memadr", obs, e_memadr);
    step; check_eq("lw_memrd", obs, e_memrd);
    step; check_eq("lw_memwb", obs, e_memwb);

    // Back in FETCH: stall 3 cycles, then sw
    step; mem_ready = 1'b0; Op_Code = 6'b101011; #1;
    check_eq("stall_fetch_0", obs, e_fetch_wait);
    step; check_eq("stall_fetch_1", obs, e_fetch_wait);
    step; check_eq("stall_fetch_2", obs, e_fetch_wait);
    step; mem_ready = 1'b1; #1;
    check_eq("stall_release", obs, e_fetch);
    step; check_eq("sw_decode", obs, e_decode);
    step; check_eq("sw_memadr", obs, e_memadr);
    mem_ready = 1'b0;  // ignored in MEMADR
    step; check_eq("sw_memwr_wait", obs, e_memwr_wait);
    mem_ready = 1'b1; #1;
    check_eq("sw_memwr_done", obs, e_memwr);
    step; check_eq("sw_back_fetch", obs, e_fetch);

    // R-type slt, then unsupported funct
    Op_Code = 6'b000000; Funct = 6'b101010;
    step; check_eq("slt_decode", obs, e_decode);
    step; check_eq("slt_execute", obs, e_exec_slt);
    step; check_eq("slt_aluwb", obs, e_aluwb);
    step; Funct = 6'b000111;
    step; check_eq("badfunct_decode", obs, e_decode_ill);
    step; check_eq("badfunct_fetch", obs, e_fetch);

    // addi
    Op_Code = 6'b001000;
    step; check_eq("addi_decode", obs, e_decode);
    step; check_eq("addi_ex", obs, e_addiex);
    step; check_eq("addi_wb", obs, e_addiwb);

    // beq taken and not taken
    step; Op_Code = 6'b000100; zero = 1'b1;
    step; check_eq("beq_t_decode", obs, e_decode);
    step; check_eq("beq_taken", obs, e_br_taken);
    step; zero = 1'b0;
    step;
    step; check_eq("beq_not_taken", obs, e_br_not);

    // j
    step; Op_Code = 6'b000010;
    step;
    step; check_eq("jump", obs, e_jump);

    // Unsupported opcode
    step; Op_Code = 6'b111111;
    step; check_eq("illop_decode", obs, e_decode_ill);
    step; check_eq("illop_fetch", obs, e_fetch);

    // bne with zero=0
    Op_Code = 6'b000101; zero = 1'b0;
    step;
`ifdef BNE_EN
    check_eq("bne_decode", obs, e_decode);
    step; check_eq("bne_taken", obs, e_br_taken);
`else
    check_eq("bne_illegal", obs, e_decode_ill);
`endif
    step; check_eq("bne_after_fetch", obs, e_fetch);

    // Reset while waiting in MEMRD
    Op_Code = 6'b100011;
    step; step; mem_ready = 1'b0;
    step; check_eq("rst_pre_memrd", obs, e_memrd);
    step; check_eq("memrd_hold", obs, e_memrd);
    rst = 1'b1; #1;
    check_eq("rst_midop", obs, e_idle);
    step; check_eq("rst_held_idle", obs, e_idle);
    @(negedge clk) rst = 1'b0;
    step; check_eq("rst_release_fetch", obs, e_fetch_wait);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
